lockstep_compare_n: RTL
=======================

# lockstep_compare_n

Parametrised lockstep checker that takes the output buses of two implementations of the same block, a golden model and a candidate, and compares them lane by lane on every valid cycle. It forwards the golden bus and raises a registered mismatch pulse. It also keeps a sticky error flag, a saturating error count and a capture of the first divergence (lane, cycle, both values). It generalises the fixed XOR wrapper around the control-path models: any lane count and lane width, per-lane masking, a reset warm-up window and a stop/continue mode.

## Interface
- LANE_W, 32, bits per compared lane
- NLANES, 9, number of lanes; compared bus width is NLANES*LANE_W, unused top bits tied equal by the instantiator
- WARMUP, 2, valid samples ignored after reset, 0..255
- CNT_W, 32, sample counter width
- ERR_W, 16, error counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid  in  1  sample strobe for gold_in/dut_in
- gold_in  in  NLANES*LANE_W  golden model outputs, lane k = bits [k*LANE_W +: LANE_W]
- dut_in  in  NLANES*LANE_W  candidate outputs, same packing
- lane_mask  in  NLANES  1 = lane compared; sampled with valid
- stop_on_first  in  1  1 = freeze err_count after first mismatch
- clear  in  1  re-arm: drop error, counts and captures
- out_data  out  NLANES*LANE_W  registered gold_in
- out_valid  out  1  registered valid
- mismatch  out  1  one-cycle pulse, compared lanes differ
- mismatch_lanes  out  NLANES  per-lane differ flags (masked)
- error  out  1  sticky
- first_lane  out  $clog2(NLANES)  lowest mismatching lane of first divergence
- first_cycle  out  CNT_W  sample index of first divergence
- first_gold, first_dut  out  LANE_W  lane values at first divergence
- err_count  out  ERR_W  mismatching samples, saturating
- state  out  2  WARMUP=0, ARMED=1, TRIPPED=2

## Operation
- diff[k] = valid & lane_mask[k] & (gold lane k != dut lane k); any = |diff.
- sample_cnt increments on every valid sample (all states) and saturates at all-ones. A sample's index is the count value before the increment.
- State machine:
  - WARMUP: each valid decrements warm_left. When a valid arrives with warm_left==1, go to ARMED. If WARMUP==0, reset enters ARMED directly. Diffs are ignored and mismatch, mismatch_lanes and error stay 0.
  - ARMED: any -> TRIPPED. On that same edge: error<=1; capture first_lane (lowest set diff index), first_cycle, first_gold and first_dut of that lane; err_count<=1.
  - TRIPPED: captures hold. err_count increments on each further `any` unless stop_on_first=1. It saturates at 2^ERR_W-1.
- mismatch and mismatch_lanes report every differing sample in ARMED and TRIPPED, regardless of stop_on_first.
- clear in any state:
  - Goes to ARMED with no warm-up.
  - Zeros error, err_count, captures and sample_cnt.
  - That cycle's sample is not compared: mismatch=0 on the next cycle.
  - clear has priority over a same-cycle mismatch.
- reset has priority over clear. Reset mid-divergence discards all captured state.
- out_data and out_valid track gold_in and valid unconditionally; no stall and no backpressure.

## Timing
- Latency 1: inputs at edge t appear on out_data, out_valid, mismatch, mismatch_lanes, error, captures and err_count after edge t.
- Throughput one sample per clock.
- Reset values: out_data 0, out_valid 0, mismatch 0, mismatch_lanes 0, error 0, first_lane 0, first_cycle 0, first_gold 0, first_dut 0, err_count 0, state WARMUP (ARMED if WARMUP==0), sample_cnt 0, warm_left WARMUP.
- valid=0 cycles: no compare, no counting, state unchanged.
- A mismatch with lane_mask all zero never trips.

## Structure
- Shared package lockstep_pkg holds the state enum (WARMUP/ARMED/TRIPPED) and the lane-slice helper function.
- Sub-module lockstep_first_lane: NLANES-wide lowest-index priority encoder returning the index and a found flag, used for the first_lane capture and the capture mux.
- Top: compare array, FSM, counters, capture registers.

## Test plan
- Equal buses, LANE_W=32, NLANES=9, WARMUP=2, 100 valid samples -> error=0, err_count=0, state=ARMED after 2nd valid, out_data==gold_in delayed 1.
- Warm-up: lane 3 differs on samples 0-1 only -> no mismatch pulse, error=0.
- Lanes 5 and 2 differ at sample 10 (gold 0x12345678, dut 0x12345679 on lane 2) -> mismatch pulse next cycle, mismatch_lanes=0x024, first_lane=2, first_cycle=10, first_gold=0x12345678, first_dut=0x12345679, state=TRIPPED.
- stop_on_first=0, 3 more mismatching samples -> err_count=4, captures unchanged. Repeat with stop_on_first=1 -> err_count=1, mismatch still pulses.
- lane_mask[2]=0 with lane 2 differing -> no trip. Then clear asserted in a mismatching cycle -> mismatch=0, state=ARMED, all captures 0, sample_cnt restarts at 0.
- ERR_W=4, 20 mismatches with stop_on_first=0 -> err_count saturates at 15. reset mid-run -> all outputs at reset values, state=WARMUP.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep comparator: checker state encoding
// and a dynamic-index lane extractor used by the first-divergence capture mux.
package lockstep_pkg;

    // Upper bounds for the lane-slice helper; buses and lanes must fit inside them.
    localparam int MAX_BUS_W  = 4096;
    localparam int MAX_LANE_W = 128;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TRIPPED = 2'd2
    } lockstep_state_e;

    function automatic logic [MAX_LANE_W-1:0] laneSlice(
        input logic [MAX_BUS_W-1:0] bus,
        input logic [31:0]          lane,
        input logic [31:0]          laneW
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted = bus >> (lane * laneW);
        return shifted[MAX_LANE_W-1:0];
    endfunction

endpackage

// File: rtl/lockstep_first_lane.sv
// Lowest-index priority encoder over the per-lane difference flags; picks the
// lane whose values are captured when the checker first trips.
module lockstep_first_lane
    import lockstep_pkg::*;
#(
    parameter int NLANES = 9,
    parameter int IDX_W  = 4
) (
    input  logic [NLANES-1:0] req_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              found_o
);

    // Scanning downward lets the lowest set lane win the last assignment.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = NLANES - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_o   = IDX_W'(k);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lockstep_compare_n.sv
// Lane-wise lockstep checker between a golden model and a candidate bus, with
// warm-up window, sticky error, saturating counts and first-divergence capture.
module lockstep_compare_n
    import lockstep_pkg::*;
#(
    parameter int LANE_W = 32,
    parameter int NLANES = 9,
    parameter int WARMUP = 2,
    parameter int CNT_W  = 32,
    parameter int ERR_W  = 16,
    localparam int BUS_W = NLANES * LANE_W,
    localparam int IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [BUS_W-1:0]   gold_in,
    input  logic [BUS_W-1:0]   dut_in,
    input  logic [NLANES-1:0]  lane_mask,
    input  logic               stop_on_first,
    input  logic               clear,
    output logic [BUS_W-1:0]   out_data,
    output logic               out_valid,
    output logic               mismatch,
    output logic [NLANES-1:0]  mismatch_lanes,
    output logic               error,
    output logic [IDX_W-1:0]   first_lane,
    output logic [CNT_W-1:0]   first_cycle,
    output logic [LANE_W-1:0]  first_gold,
    output logic [LANE_W-1:0]  first_dut,
    output logic [ERR_W-1:0]   err_count,
    output logic [1:0]         state
);

    lockstep_state_e    state_q, state_d;
    logic [7:0]         warmLeft_q, warmLeft_d;
    logic [CNT_W-1:0]   sampleCnt_q, sampleCnt_d;
    logic [BUS_W-1:0]   outData_q;
    logic               outValid_q;
    logic               mismatch_q, mismatch_d;
    logic [NLANES-1:0]  lanes_q, lanes_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   firstLane_q, firstLane_d;
    logic [CNT_W-1:0]   firstCycle_q, firstCycle_d;
    logic [LANE_W-1:0]  firstGold_q, firstGold_d;
    logic [LANE_W-1:0]  firstDut_q, firstDut_d;
    logic [ERR_W-1:0]   errCount_q, errCount_d;

    logic [NLANES-1:0]  diff;
    logic [IDX_W-1:0]   firstIdx;
    logic               anyDiff;
    logic [LANE_W-1:0]  goldSel, dutSel;

    for (genvar k = 0; k < NLANES; k++) begin : g_cmp
        assign diff[k] = valid & lane_mask[k] &
                         (gold_in[k*LANE_W +: LANE_W] != dut_in[k*LANE_W +: LANE_W]);
    end

    lockstep_first_lane #(
        .NLANES (NLANES),
        .IDX_W  (IDX_W)
    ) u_firstLane (
        .req_i   (diff),
        .idx_o   (firstIdx),
        .found_o (anyDiff)
    );

    assign goldSel = LANE_W'(laneSlice(MAX_BUS_W'(gold_in), 32'(firstIdx), 32'(LANE_W)));
    assign dutSel  = LANE_W'(laneSlice(MAX_BUS_W'(dut_in),  32'(firstIdx), 32'(LANE_W)));

    // Clear re-arms without warm-up and swallows its own sample; otherwise only
    // valid samples advance counters, and diffs matter only once armed.
    always_comb begin
        state_d      = state_q;
        warmLeft_d   = warmLeft_q;
        sampleCnt_d  = sampleCnt_q;
        mismatch_d   = 1'b0;
        lanes_d      = '0;
        error_d      = error_q;
        firstLane_d  = firstLane_q;
        firstCycle_d = firstCycle_q;
        firstGold_d  = firstGold_q;
        firstDut_d   = firstDut_q;
        errCount_d   = errCount_q;

        if (clear) begin
            state_d      = ST_ARMED;
            warmLeft_d   = '0;
            sampleCnt_d  = '0;
            error_d      = 1'b0;
            firstLane_d  = '0;
            firstCycle_d = '0;
            firstGold_d  = '0;
            firstDut_d   = '0;
            errCount_d   = '0;
        end else if (valid) begin
            if (sampleCnt_q != '1) begin
                sampleCnt_d = sampleCnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_WARMUP: begin
                    warmLeft_d = warmLeft_q - 8'd1;
                    if (warmLeft_q <= 8'd1) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    mismatch_d = anyDiff;
                    lanes_d    = diff;
                    if (anyDiff) begin
                        state_d      = ST_TRIPPED;
                        error_d      = 1'b1;
                        firstLane_d  = firstIdx;
                        firstCycle_d = sampleCnt_q;
                        firstGold_d  = goldSel;
                        firstDut_d   = dutSel;
                        errCount_d   = ERR_W'(1);
                    end
                end
                ST_TRIPPED: begin
                    mismatch_d = anyDiff;
                    lanes_d    = diff;
                    if (anyDiff && !stop_on_first && (errCount_q != '1)) begin
                        errCount_d = errCount_q + ERR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
    end

    // Output data/valid follow the golden bus every cycle, independent of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= (WARMUP == 0) ? ST_ARMED : ST_WARMUP;
            warmLeft_q   <= 8'(WARMUP);
            sampleCnt_q  <= '0;
            outData_q    <= '0;
            outValid_q   <= 1'b0;
            mismatch_q   <= 1'b0;
            lanes_q      <= '0;
            error_q      <= 1'b0;
            firstLane_q  <= '0;
            firstCycle_q <= '0;
            firstGold_q  <= '0;
            firstDut_q   <= '0;
            errCount_q   <= '0;
        end else begin
            state_q      <= state_d;
            warmLeft_q   <= warmLeft_d;
            sampleCnt_q  <= sampleCnt_d;
            outData_q    <= gold_in;
            outValid_q   <= valid;
            mismatch_q   <= mismatch_d;
            lanes_q      <= lanes_d;
            error_q      <= error_d;
            firstLane_q  <= firstLane_d;
            firstCycle_q <= firstCycle_d;
            firstGold_q  <= firstGold_d;
            firstDut_q   <= firstDut_d;
            errCount_q   <= errCount_d;
        end
    end

    assign out_data       = outData_q;
    assign out_valid      = outValid_q;
    assign mismatch       = mismatch_q;
    assign mismatch_lanes = lanes_q;
    assign error          = error_q;
    assign first_lane     = firstLane_q;
    assign first_cycle    = firstCycle_q;
    assign first_gold     = firstGold_q;
    assign first_dut      = firstDut_q;
    assign err_count      = errCount_q;
    assign state          = state_q;

endmodule
